// File: rtl/instr_cache_ctrl_nway.sv
// N-way set-associative instruction cache controller: hit detection, victim selection,
// AHB line fill, uncached bypass and tree pseudo-LRU update.
// Define ICACHE_CRITICAL_WORD_FIRST_EN to start each fill at the requested word (wrapping burst).
module instr_cache_ctrl_nway #(
    parameter int TBITS = 14,
    parameter int WAYS  = 4,
    parameter int WORDS = 4,
    localparam int OBITS = $clog2(WORDS),
    localparam int WBITS = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  PAReadyF,
    input  logic [TBITS-1:0]      PhysTag,
    input  logic [OBITS-1:0]      WordOffset,
    input  logic [WAYS-1:0]       ValidW,
    input  logic [WAYS*TBITS-1:0] TagW,
    input  logic [WAYS-2:0]       PLRUIn,
    input  logic                  BusReady,
    output logic [WAYS-1:0]       WaySel,
    output logic [WAYS-1:0]       WayWE,
    output logic [WAYS-2:0]       PLRUOut,
    output logic                  PLRUWE,
    output logic                  IStall,
    output logic                  HRequestF,
    output logic [OBITS-1:0]      AddrWordOffset,
    output logic [OBITS-1:0]      DataWordOffset
);

    typedef enum logic [1:0] {READY, FILL, LAST, DONE} state_t;

    state_t           state_q, state_d;
    logic [OBITS-1:0] addrCnt_q, addrCnt_d;
    logic [OBITS-1:0] dataCnt_q, dataCnt_d;
    logic [OBITS-1:0] startOff_q, startOff_d;
    logic [WBITS-1:0] victim_q, victim_d;
    logic             bypass_q, bypass_d;
    logic             dataPhase_q, dataPhase_d;

    logic [WAYS-1:0]  hitW;
    logic [WAYS-1:0]  hitOneHot;
    logic [WBITS-1:0] hitIdx;
    logic             hit;
    logic [WBITS-1:0] victimSel;
    logic [WBITS-1:0] plruWay;
    logic [WBITS-1:0] touched;
    logic [WAYS-1:0]  victimOneHot;
    logic             inReady, inFill, inLast, inDone;

    // Tag compare; descending scan makes the lowest matching way win.
    always_comb begin
        hitW   = '0;
        hitIdx = '0;
        for (int i = 0; i < WAYS; i++) begin
            hitW[i] = ValidW[i] && (TagW[i*TBITS +: TBITS] == PhysTag);
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hitW[i]) hitIdx = WBITS'(i);
        end
        hitOneHot = (|hitW) ? (WAYS'(1) << hitIdx) : '0;
        hit       = (|hitW) && PAReadyF && enable;
    end

    // Replacement choice: an invalid way if any, otherwise follow the PLRU tree (0 = go low).
    always_comb begin
        int node;
        node = 0;
        for (int l = 0; l < WBITS; l++) begin
            node = 2 * node + 1 + (PLRUIn[node] ? 1 : 0);
        end
        plruWay   = WBITS'(node - (WAYS - 1));
        victimSel = plruWay;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!ValidW[i]) victimSel = WBITS'(i);
        end
    end

    // Point every tree node on the touched way's path away from it.
    always_comb begin
        int  node;
        logic dir;
        touched = (state_q == DONE) ? victim_q : hitIdx;
        PLRUOut = PLRUIn;
        node    = 0;
        for (int l = 0; l < WBITS; l++) begin
            dir           = touched[WBITS-1-l];
            PLRUOut[node] = ~dir;
            node          = 2 * node + 1 + (dir ? 1 : 0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= READY;
            addrCnt_q   <= '0;
            dataCnt_q   <= '0;
            startOff_q  <= '0;
            victim_q    <= '0;
            bypass_q    <= 1'b0;
            dataPhase_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addrCnt_q   <= addrCnt_d;
            dataCnt_q   <= dataCnt_d;
            startOff_q  <= startOff_d;
            victim_q    <= victim_d;
            bypass_q    <= bypass_d;
            dataPhase_q <= dataPhase_d;
        end
    end

    // The data counter only moves once the first address beat has been accepted.
    always_comb begin
        state_d     = state_q;
        addrCnt_d   = addrCnt_q;
        dataCnt_d   = dataCnt_q;
        startOff_d  = startOff_q;
        victim_d    = victim_q;
        bypass_d    = bypass_q;
        dataPhase_d = dataPhase_q;
        case (state_q)
            READY: begin
                addrCnt_d   = '0;
                dataCnt_d   = '0;
                dataPhase_d = 1'b0;
                if (PAReadyF && !hit) begin
                    if (enable) begin
                        state_d  = FILL;
                        victim_d = victimSel;
                        bypass_d = 1'b0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                        startOff_d = WordOffset;
`else
                        startOff_d = '0;
`endif
                    end else begin
                        state_d  = LAST;
                        bypass_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (BusReady) begin
                    addrCnt_d   = addrCnt_q + 1'b1;
                    dataPhase_d = 1'b1;
                    if (dataPhase_q) dataCnt_d = dataCnt_q + 1'b1;
                    if (addrCnt_q == OBITS'(WORDS - 1)) state_d = LAST;
                end
            end
            LAST: begin
                if (BusReady) begin
                    state_d = DONE;
                    if (!bypass_q) dataCnt_d = dataCnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d  = READY;
                bypass_d = 1'b0;
            end
            default: state_d = READY;
        endcase
    end

    // Strobes are held low while reset is asserted so an aborted fill writes nothing more.
    always_comb begin
        inReady      = (state_q == READY);
        inFill       = (state_q == FILL);
        inLast       = (state_q == LAST);
        inDone       = (state_q == DONE);
        victimOneHot = WAYS'(1) << victim_q;

        WayWE = '0;
        if (!reset && BusReady && !bypass_q && ((inFill && dataPhase_q) || inLast)) begin
            WayWE = victimOneHot;
        end

        if (!enable)      WaySel = WAYS'(1);
        else if (inReady) WaySel = hitOneHot;
        else              WaySel = victimOneHot;

        if ((inFill || inLast) && !bypass_q) begin
            AddrWordOffset = startOff_q + addrCnt_q;
            DataWordOffset = startOff_q + dataCnt_q;
        end else begin
            AddrWordOffset = WordOffset;
            DataWordOffset = WordOffset;
        end

        IStall    = !reset && (inFill || inLast || (inReady && PAReadyF && !hit));
        HRequestF = !reset && PAReadyF && (inFill || (inReady && !hit) || (inLast && !BusReady));
        PLRUWE    = !reset && ((inReady && hit) || (inDone && !bypass_q));
    end

endmodule

// File: tb/tb_instr_cache_ctrl_nway.sv
// Directed self-checking bench for instr_cache_ctrl_nway (WAYS=4, WORDS=4, TBITS=14).
// Works with or without ICACHE_CRITICAL_WORD_FIRST_EN defined.
module tb_instr_cache_ctrl_nway;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        PAReadyF;
    logic [13:0] PhysTag;
    logic [1:0]  WordOffset;
    logic [3:0]  ValidW;
    logic [55:0] TagW;
    logic [2:0]  PLRUIn;
    logic        BusReady;
    logic [3:0]  WaySel;
    logic [3:0]  WayWE;
    logic [2:0]  PLRUOut;
    logic        PLRUWE;
    logic        IStall;
    logic        HRequestF;
    logic [1:0]  AddrWordOffset;
    logic [1:0]  DataWordOffset;

    int checks = 0;
    int errors = 0;

    instr_cache_ctrl_nway dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .PAReadyF      (PAReadyF),
        .PhysTag       (PhysTag),
        .WordOffset    (WordOffset),
        .ValidW        (ValidW),
        .TagW          (TagW),
        .PLRUIn        (PLRUIn),
        .BusReady      (BusReady),
        .WaySel        (WaySel),
        .WayWE         (WayWE),
        .PLRUOut       (PLRUOut),
        .PLRUWE        (PLRUWE),
        .IStall        (IStall),
        .HRequestF     (HRequestF),
        .AddrWordOffset(AddrWordOffset),
        .DataWordOffset(DataWordOffset)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; PAReadyF = 1'b0; PhysTag = '0; WordOffset = 2'd1;
        ValidW = '0; TagW = '0; PLRUIn = '0; BusReady = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (IStall !== 1'b0) begin errors++; $display("[TB] FAIL reset_istall got %0b exp 0", IStall); end
        checks++; if (HRequestF !== 1'b0) begin errors++; $display("[TB] FAIL reset_hreq got %0b exp 0", HRequestF); end
        checks++; if (WayWE !== 4'b0000) begin errors++; $display("[TB] FAIL reset_waywe got %b exp 0000", WayWE); end
        checks++; if (PLRUWE !== 1'b0) begin errors++; $display("[TB] FAIL reset_plruwe got %0b exp 0", PLRUWE); end
        checks++; if (AddrWordOffset !== 2'd1) begin errors++; $display("[TB] FAIL reset_addroff got %0d exp 1", AddrWordOffset); end
        checks++; if (DataWordOffset !== 2'd1) begin errors++; $display("[TB] FAIL reset_dataoff got %0d exp 1", DataWordOffset); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (IStall !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_istall got %0b exp 0", IStall); end
    endtask

    task automatic test_hit();
        @(negedge clk);
        enable = 1'b1; PAReadyF = 1'b1; PhysTag = 14'h1A2B; PLRUIn = 3'b000;
        ValidW = 4'b0100;
        TagW   = {14'h0000, 14'h1A2B, 14'h0123, 14'h1A2B};
        #1;
        checks++; if (WaySel !== 4'b0100) begin errors++; $display("[TB] FAIL hit_waysel got %b exp 0100", WaySel); end
        checks++; if (IStall !== 1'b0) begin errors++; $display("[TB] FAIL hit_istall got %0b exp 0", IStall); end
        checks++; if (HRequestF !== 1'b0) begin errors++; $display("[TB] FAIL hit_hreq got %0b exp 0", HRequestF); end
        checks++; if (PLRUWE !== 1'b1) begin errors++; $display("[TB] FAIL hit_plruwe got %0b exp 1", PLRUWE); end
        checks++; if (PLRUOut !== 3'b100) begin errors++; $display("[TB] FAIL hit_plruout got %b exp 100", PLRUOut); end
        @(negedge clk);
        PAReadyF = 1'b0;
        #1;
        checks++; if (PLRUWE !== 1'b0) begin errors++; $display("[TB] FAIL hit_plruwe_idle got %0b exp 0", PLRUWE); end
        @(negedge clk);
        PAReadyF = 1'b1; ValidW = 4'b0110;
        TagW = {14'h0000, 14'h1A2B, 14'h1A2B, 14'h0000};
        #1;
        checks++; if (WaySel !== 4'b0010) begin errors++; $display("[TB] FAIL multihit_waysel got %b exp 0010", WaySel); end
        checks++; if (PLRUOut !== 3'b001) begin errors++; $display("[TB] FAIL multihit_plruout got %b exp 001", PLRUOut); end
        @(negedge clk);
        PAReadyF = 1'b0;
    endtask

    task automatic test_fill_miss();
        logic [1:0] startExp;
        logic [1:0] expOff;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        startExp = 2'd2;
`else
        startExp = 2'd0;
`endif
        @(negedge clk);
        enable = 1'b1; PAReadyF = 1'b1; PhysTag = 14'h1111; WordOffset = 2'd2;
        ValidW = 4'b1111; TagW = {14'h0004, 14'h0003, 14'h0002, 14'h0001};
        PLRUIn = 3'b000; BusReady = 1'b1;
        #1;
        checks++; if (IStall !== 1'b1) begin errors++; $display("[TB] FAIL miss_istall got %0b exp 1", IStall); end
        checks++; if (HRequestF !== 1'b1) begin errors++; $display("[TB] FAIL miss_hreq got %0b exp 1", HRequestF); end
        checks++; if (WayWE !== 4'b0000) begin errors++; $display("[TB] FAIL miss_waywe got %b exp 0000", WayWE); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            expOff = startExp + 2'(k - 1);
            checks++; if (AddrWordOffset !== expOff) begin errors++; $display("[TB] FAIL fill_addroff beat %0d got %0d exp %0d", k, AddrWordOffset, expOff); end
            if (k >= 2) begin
                expOff = startExp + 2'(k - 2);
                checks++; if (WayWE !== 4'b0001) begin errors++; $display("[TB] FAIL fill_waywe beat %0d got %b exp 0001", k, WayWE); end
                checks++; if (DataWordOffset !== expOff) begin errors++; $display("[TB] FAIL fill_dataoff beat %0d got %0d exp %0d", k, DataWordOffset, expOff); end
            end else begin
                checks++; if (WayWE !== 4'b0000) begin errors++; $display("[TB] FAIL fill_first_waywe got %b exp 0000", WayWE); end
            end
        end
        @(negedge clk);
        #1;
        expOff = startExp + 2'd3;
        checks++; if (WayWE !== 4'b0001) begin errors++; $display("[TB] FAIL last_waywe got %b exp 0001", WayWE); end
        checks++; if (DataWordOffset !== expOff) begin errors++; $display("[TB] FAIL last_dataoff got %0d exp %0d", DataWordOffset, expOff); end
        checks++; if (HRequestF !== 1'b0) begin errors++; $display("[TB] FAIL last_hreq got %0b exp 0", HRequestF); end
        checks++; if (IStall !== 1'b1) begin errors++; $display("[TB] FAIL last_istall got %0b exp 1", IStall); end
        @(negedge clk);
        PAReadyF = 1'b0;
        #1;
        checks++; if (IStall !== 1'b0) begin errors++; $display("[TB] FAIL done_istall got %0b exp 0", IStall); end
        checks++; if (PLRUWE !== 1'b1) begin errors++; $display("[TB] FAIL done_plruwe got %0b exp 1", PLRUWE); end
        checks++; if (PLRUOut !== 3'b011) begin errors++; $display("[TB] FAIL done_plruout got %b exp 011", PLRUOut); end
        checks++; if (WaySel !== 4'b0001) begin errors++; $display("[TB] FAIL done_waysel got %b exp 0001", WaySel); end
        checks++; if (WayWE !== 4'b0000) begin errors++; $display("[TB] FAIL done_waywe got %b exp 0000", WayWE); end
        @(negedge clk);
        #1;
        checks++; if (PLRUWE !== 1'b0) begin errors++; $display("[TB] FAIL ready_plruwe got %0b exp 0", PLRUWE); end
        checks++; if (IStall !== 1'b0) begin errors++; $display("[TB] FAIL ready_istall got %0b exp 0", IStall); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        enable = 1'b0; PAReadyF = 1'b1; WordOffset = 2'd3; BusReady = 1'b1;
        ValidW = 4'b1111; PhysTag = 14'h1111;
        #1;
        checks++; if (HRequestF !== 1'b1) begin errors++; $display("[TB] FAIL byp_hreq got %0b exp 1", HRequestF); end
        checks++; if (IStall !== 1'b1) begin errors++; $display("[TB] FAIL byp_istall got %0b exp 1", IStall); end
        checks++; if (WaySel !== 4'b0001) begin errors++; $display("[TB] FAIL byp_waysel got %b exp 0001", WaySel); end
        checks++; if (AddrWordOffset !== 2'd3) begin errors++; $display("[TB] FAIL byp_addroff got %0d exp 3", AddrWordOffset); end
        @(negedge clk);
        #1;
        checks++; if (WayWE !== 4'b0000) begin errors++; $display("[TB] FAIL byp_last_waywe got %b exp 0000", WayWE); end
        checks++; if (IStall !== 1'b1) begin errors++; $display("[TB] FAIL byp_last_istall got %0b exp 1", IStall); end
        checks++; if (DataWordOffset !== 2'd3) begin errors++; $display("[TB] FAIL byp_dataoff got %0d exp 3", DataWordOffset); end
        @(negedge clk);
        PAReadyF = 1'b0;
        #1;
        checks++; if (IStall !== 1'b0) begin errors++; $display("[TB] FAIL byp_done_istall got %0b exp 0", IStall); end
        checks++; if (PLRUWE !== 1'b0) begin errors++; $display("[TB] FAIL byp_done_plruwe got %0b exp 0", PLRUWE); end
        checks++; if (WayWE !== 4'b0000) begin errors++; $display("[TB] FAIL byp_done_waywe got %b exp 0000", WayWE); end
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic test_stall_enable_drop();
        int         writes;
        logic       done;
        logic       prevBR;
        logic [1:0] lastAddr;
        writes = 0; done = 1'b0; prevBR = 1'b1; lastAddr = '0;
        @(negedge clk);
        enable = 1'b1; PAReadyF = 1'b1; WordOffset = 2'd0; PhysTag = 14'h1111;
        ValidW = 4'b1111; TagW = {14'h0004, 14'h0003, 14'h0002, 14'h0001};
        PLRUIn = 3'b101; BusReady = 1'b1;
        #1;
        checks++; if (IStall !== 1'b1) begin errors++; $display("[TB] FAIL stall_miss_istall got %0b exp 1", IStall); end
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            BusReady = (cyc >= 2 && cyc <= 4) ? 1'b0 : 1'b1;
            if (cyc == 1) enable = 1'b0;
            #1;
            if (!done) begin
                if (IStall === 1'b0) begin
                    done = 1'b1;
                    checks++; if (writes != 4) begin errors++; $display("[TB] FAIL stall_write_count got %0d exp 4", writes); end
                    checks++; if (PLRUWE !== 1'b1) begin errors++; $display("[TB] FAIL stall_done_plruwe got %0b exp 1", PLRUWE); end
                    checks++; if (PLRUOut !== 3'b000) begin errors++; $display("[TB] FAIL stall_done_plruout got %b exp 000", PLRUOut); end
                    PAReadyF = 1'b0;
                end else begin
                    if (WayWE !== 4'b0000) begin
                        checks++; if (WayWE !== 4'b1000) begin errors++; $display("[TB] FAIL stall_waywe got %b exp 1000", WayWE); end
                        checks++; if (DataWordOffset !== 2'(writes)) begin errors++; $display("[TB] FAIL stall_dataoff got %0d exp %0d", DataWordOffset, writes); end
                        writes++;
                    end
                    if (BusReady == 1'b0) begin
                        checks++; if (WayWE !== 4'b0000) begin errors++; $display("[TB] FAIL stall_waywe_low got %b exp 0000", WayWE); end
                    end
                    if (prevBR == 1'b0) begin
                        checks++; if (AddrWordOffset !== lastAddr) begin errors++; $display("[TB] FAIL stall_addr_frozen got %0d exp %0d", AddrWordOffset, lastAddr); end
                    end
                    lastAddr = AddrWordOffset;
                    prevBR   = BusReady;
                end
            end
        end
        checks++; if (!done) begin errors++; $display("[TB] FAIL stall_timeout got busy exp done"); end
        @(negedge clk);
        enable = 1'b1; PAReadyF = 1'b0; BusReady = 1'b1;
    endtask

    task automatic test_reset_midfill();
        @(negedge clk);
        enable = 1'b1; PAReadyF = 1'b1; WordOffset = 2'd0; PhysTag = 14'h1111;
        ValidW = 4'b1011; TagW = {14'h0004, 14'h0003, 14'h0002, 14'h0001};
        PLRUIn = 3'b000; BusReady = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (WaySel !== 4'b0100) begin errors++; $display("[TB] FAIL invalid_victim_waysel got %b exp 0100", WaySel); end
        @(negedge clk);
        #1;
        checks++; if (WayWE !== 4'b0100) begin errors++; $display("[TB] FAIL invalid_victim_waywe got %b exp 0100", WayWE); end
        #2;
        reset = 1'b1; PAReadyF = 1'b0;
        #1;
        checks++; if (WayWE !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_waywe got %b exp 0000", WayWE); end
        checks++; if (IStall !== 1'b0) begin errors++; $display("[TB] FAIL midreset_istall got %0b exp 0", IStall); end
        checks++; if (HRequestF !== 1'b0) begin errors++; $display("[TB] FAIL midreset_hreq got %0b exp 0", HRequestF); end
        checks++; if (PLRUWE !== 1'b0) begin errors++; $display("[TB] FAIL midreset_plruwe got %0b exp 0", PLRUWE); end
        @(negedge clk);
        reset = 1'b0; WordOffset = 2'd3;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (WayWE !== 4'b0000) begin errors++; $display("[TB] FAIL postreset_waywe cyc %0d got %b exp 0000", c, WayWE); end
            checks++; if (IStall !== 1'b0) begin errors++; $display("[TB] FAIL postreset_istall cyc %0d got %0b exp 0", c, IStall); end
            checks++; if (AddrWordOffset !== 2'd3) begin errors++; $display("[TB] FAIL postreset_addroff cyc %0d got %0d exp 3", c, AddrWordOffset); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_fill_miss();
        test_bypass();
        test_stall_enable_drop();
        test_reset_midfill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
